// File: rtl/led_strand_scheduler.sv
// APA102 frame sequencer sharing one SPI link among NUM_STRANDS requesters.
// Define APA102_LONG_END_EN to stretch the end frame to max(32, roundup32(ceil(led_cnt/2))) ones.
module led_strand_scheduler #(
    parameter int NUM_STRANDS = 4,
    parameter int LED_MAX     = 128,
    parameter int DIV         = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_STRANDS-1:0] frame_req,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [23:0]            pix_data,
    input  logic                   pix_last,
    input  logic [4:0]             globalbrightness,
    output logic [NUM_STRANDS-1:0] grant,
    output logic                   busy,
    output logic                   sck,
    output logic                   mosi,
    output logic                   frame_done,
    output logic [7:0]             led_cnt,
    output logic [2:0]             dbg_state
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(NUM_STRANDS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_PIX_WAIT, S_LED, S_END, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_STRANDS-1:0] grant_q, grant_d;
    logic                   sck_q, sck_d;
    logic                   mosi_q, mosi_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [4:0]             bit_q, bit_d;
    logic [31:0]            shreg_q, shreg_d;
    logic                   last_q, last_d;
    logic [7:0]             led_cnt_q, led_cnt_d;
    logic [2:0]             word_q, word_d;
    logic [2:0]             end_words_q, end_words_d;

    logic                   arb_found;
    logic [PTR_W-1:0]       arb_idx;
    logic                   shifting, div_wrap, bit_end;
    logic [2:0]             end_words_calc;

    // Round-robin: first requesting strand at or after ptr_q, wrapping.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_STRANDS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_STRANDS;
            if (!arb_found && frame_req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(idx);
            end
        end
    end

`ifdef APA102_LONG_END_EN
    // Number of 32-bit words of ones: ceil(ceil(n/2)/32) == ceil(n/64), at least one.
    always_comb begin
        end_words_calc = 3'((9'(led_cnt_q) + 9'd63) >> 6);
        if (end_words_calc == 3'd0) end_words_calc = 3'd1;
    end
`else
    assign end_words_calc = 3'd1;
`endif

    assign shifting = (state_q == S_START) || (state_q == S_LED) || (state_q == S_END);
    assign div_wrap = (div_q == DIV_W'(DIV - 1));
    assign bit_end  = shifting && div_wrap && sck_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        last_d      = last_q;
        led_cnt_d   = led_cnt_q;
        word_d      = word_q;
        end_words_d = end_words_q;

        // Each bit: DIV cycles sck low, DIV cycles sck high; bit ends on the falling edge.
        if (shifting) begin
            if (div_wrap) begin
                div_d = '0;
                sck_d = ~sck_q;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        if (bit_end) bit_d = bit_q + 5'd1;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d   = S_START;
                    grant_d   = NUM_STRANDS'(1) << arb_idx;
                    ptr_d     = (int'(arb_idx) == NUM_STRANDS - 1) ? '0 : arb_idx + 1'b1;
                    led_cnt_d = 8'd0;
                    sck_d     = 1'b0;
                    mosi_d    = 1'b0;
                    div_d     = '0;
                    bit_d     = 5'd0;
                end
            end
            S_START: begin
                if (bit_end && bit_q == 5'd31) state_d = S_PIX_WAIT;
                mosi_d = 1'b0;
            end
            S_PIX_WAIT: begin
                if (pix_valid) begin
                    state_d = S_LED;
                    mosi_d  = 1'b1;
                    shreg_d = {2'b11, globalbrightness, pix_data, 1'b0};
                    last_d  = pix_last;
                    if (led_cnt_q < 8'(LED_MAX)) led_cnt_d = led_cnt_q + 8'd1;
                    div_d   = '0;
                    bit_d   = 5'd0;
                    sck_d   = 1'b0;
                end
            end
            S_LED: begin
                if (bit_end) begin
                    if (bit_q == 5'd31) begin
                        if (last_q || led_cnt_q == 8'(LED_MAX)) begin
                            state_d     = S_END;
                            mosi_d      = 1'b1;
                            word_d      = 3'd0;
                            end_words_d = end_words_calc;
                        end else begin
                            state_d = S_PIX_WAIT;
                            mosi_d  = 1'b0;
                        end
                    end else begin
                        mosi_d  = shreg_q[31];
                        shreg_d = {shreg_q[30:0], 1'b0};
                    end
                end
            end
            S_END: begin
                if (bit_end && bit_q == 5'd31) begin
                    if (word_q == end_words_q - 3'd1) begin
                        state_d = S_DONE;
                        mosi_d  = 1'b0;
                        grant_d = '0;
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            div_q       <= '0;
            bit_q       <= 5'd0;
            shreg_q     <= 32'd0;
            last_q      <= 1'b0;
            led_cnt_q   <= 8'd0;
            word_q      <= 3'd0;
            end_words_q <= 3'd1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            last_q      <= last_d;
            led_cnt_q   <= led_cnt_d;
            word_q      <= word_d;
            end_words_q <= end_words_d;
        end
    end

    assign pix_ready  = (state_q == S_PIX_WAIT);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign grant      = grant_q;
    assign sck        = sck_q;
    assign mosi       = mosi_q;
    assign led_cnt    = led_cnt_q;
    assign dbg_state  = state_q;

endmodule
